// File: rtl/ex_divider.sv
// Multi-cycle RV32M divider for the EX stage (DIV/DIVU/REM/REMU), radix-2 restoring.
// Holds div_done/div_result in DONE until the EX stage acknowledges or the pipe flushes.
module ex_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_flush,
    input  logic            div_start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] div_dividend,
    input  logic [XLEN-1:0] div_divisor,
    input  logic            div_ack,
    output logic            div_done,
    output logic            div_busy,
    output logic [XLEN-1:0] div_result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q;
    logic            op_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN-1:0] result_q;
    logic [CW-1:0]   cnt_q;

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            sgn_ovf;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] final_res;

    always_comb begin
        is_signed = ~div_op[0];
        a_neg     = is_signed & div_dividend[XLEN-1];
        b_neg     = is_signed & div_divisor[XLEN-1];
        a_abs     = a_neg ? -div_dividend : div_dividend;
        b_abs     = b_neg ? -div_divisor : div_divisor;
        div_zero  = (div_divisor == '0);
        sgn_ovf   = is_signed && (div_dividend == {1'b1, {(XLEN-1){1'b0}}})
                    && (div_divisor == '1);

        // Overflow case: DIV returns the dividend (most negative value), REM returns 0
        if (div_zero)
            special_res = div_op[1] ? div_dividend : '1;
        else
            special_res = div_op[1] ? '0 : div_dividend;

        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dvsr_q};
        if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end

        if (op_rem_q)
            final_res = neg_rem_q ? -rem_d : rem_d;
        else
            final_res = neg_quo_q ? -quo_d : quo_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
        end else if (pipe_flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_start) begin
                        if (div_zero || sgn_ovf) begin
                            result_q <= special_res;
                            state_q  <= S_DONE;
                        end else begin
                            op_rem_q  <= div_op[1];
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            quo_q     <= a_abs;
                            dvsr_q    <= b_abs;
                            rem_q     <= '0;
                            cnt_q     <= '0;
                            state_q   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        result_q <= final_res;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (div_ack)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign div_busy   = (state_q == S_CALC);
    assign div_done   = (state_q == S_DONE);
    assign div_result = result_q;

endmodule

// File: tb/tb_ex_divider.sv
// Bench for ex_divider: table of divide vectors plus hand-written flush/reset/hold/back-to-back
// sequences; a scoreboard queue is checked whenever div_done rises.
module tb_ex_divider;

    logic        clk;
    logic        rst_n;
    logic        pipe_flush;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_ack;
    logic        div_done;
    logic        div_busy;
    logic [31:0] div_result;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          start;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    ex_divider #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_flush   (pipe_flush),
        .div_start    (div_start),
        .div_op       (div_op),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_ack      (div_ack),
        .div_done     (div_done),
        .div_busy     (div_busy),
        .div_result   (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic monitor();
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && div_done && !prev) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", {31'b0, div_done}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_result", div_result, e.res);
                    chk("sb_latency", 32'(cyc - e.start), 32'(e.lat));
                end
            end
            prev = div_done;
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        div_op       = op;
        div_dividend = a;
        div_divisor  = b;
        div_start    = 1'b1;
    endtask

    task automatic expect_res(input logic [31:0] res, input int lat, input int start);
        exp_t e;
        e.res   = res;
        e.lat   = lat;
        e.start = start;
        sbq.push_back(e);
    endtask

    task automatic wait_done();
        @(negedge clk);
        div_start = 1'b0;
        for (int i = 0; i < 40 && !div_done; i++) @(negedge clk);
        chk("done_wait", {31'b0, div_done}, 32'd1);
        if (div_ack) @(negedge clk);
    endtask

    initial begin
        int t;
        rst_n        = 1'b0;
        pipe_flush   = 1'b0;
        div_start    = 1'b0;
        div_op       = 2'd0;
        div_dividend = '0;
        div_divisor  = '0;
        div_ack      = 1'b1;

        // op: 0 DIV, 1 DIVU, 2 REM, 3 REMU
        vecs.push_back('{2'd3, 32'd7,          32'd2,          32'd1,          33});
        vecs.push_back('{2'd0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33});
        vecs.push_back('{2'd2, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33});
        vecs.push_back('{2'd0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33});
        vecs.push_back('{2'd2, 32'd7,          32'hFFFFFFFE,   32'd1,          33});
        vecs.push_back('{2'd1, 32'd5,          32'd0,          32'hFFFFFFFF,   1});
        vecs.push_back('{2'd3, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{2'd0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1});
        vecs.push_back('{2'd2, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1});
        vecs.push_back('{2'd0, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   1});
        vecs.push_back('{2'd2, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1});
        vecs.push_back('{2'd1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33});
        vecs.push_back('{2'd0, 32'h80000000,   32'd1,          32'h80000000,   33});
        vecs.push_back('{2'd3, 32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{2'd1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33});

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'b0, div_busy}, 32'd0);
        chk("rst_done",   {31'b0, div_done}, 32'd0);
        chk("rst_result", div_result,        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // DIVU 7/2: busy window t+1..t+32, done at t+33
        drive(2'd1, 32'd7, 32'd2);
        t = cyc;
        expect_res(32'd3, 33, t);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            div_start = 1'b0;
            chk($sformatf("busy_k%0d", k), {31'b0, div_busy}, (k <= 32) ? 32'd1 : 32'd0);
            chk($sformatf("done_k%0d", k), {31'b0, div_done}, (k == 33) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("idle_busy", {31'b0, div_busy}, 32'd0);
        chk("idle_done", {31'b0, div_done}, 32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            expect_res(vecs[i].res, vecs[i].lat, cyc);
            wait_done();
        end

        // Flush in the middle of CALC, then a fresh divide
        drive(2'd1, 32'd1000, 32'd3);
        t = cyc;
        @(negedge clk);
        div_start = 1'b0;
        repeat (9) @(negedge clk);
        pipe_flush = 1'b1;
        @(negedge clk);
        pipe_flush = 1'b0;
        chk("flush_busy", {31'b0, div_busy}, 32'd0);
        chk("flush_done", {31'b0, div_done}, 32'd0);
        chk("flush_cyc",  32'(cyc - t),      32'd11);
        drive(2'd1, 32'd100, 32'd7);
        expect_res(32'd14, 33, cyc);
        wait_done();

        // Hold in DONE with ack low; operand noise must not disturb anything
        div_ack = 1'b0;
        drive(2'd1, 32'h12345678, 32'h10);
        expect_res(32'h01234567, 33, cyc);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            div_dividend = $urandom;
            div_divisor  = $urandom;
            div_op       = 2'($urandom_range(0, 3));
            @(negedge clk);
            chk("hold_done",   {31'b0, div_done}, 32'd1);
            chk("hold_result", div_result,        32'h01234567);
        end
        div_ack = 1'b1;
        @(negedge clk);
        chk("ack_done_low", {31'b0, div_done}, 32'd0);

        // Synchronous reset mid-CALC
        drive(2'd1, 32'd1000, 32'd3);
        @(negedge clk);
        div_start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy",   {31'b0, div_busy}, 32'd0);
        chk("midrst_done",   {31'b0, div_done}, 32'd0);
        chk("midrst_result", div_result,        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // rst_n glitch between edges must be invisible
        drive(2'd1, 32'd100, 32'd7);
        expect_res(32'd14, 33, cyc);
        @(negedge clk);
        div_start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("glitch_busy", {31'b0, div_busy}, 32'd1);
        wait_done();

        // start held high: sampled once per IDLE visit
        drive(2'd1, 32'd5, 32'd0);
        t = cyc;
        expect_res(32'hFFFFFFFF, 1, t);
        expect_res(32'hFFFFFFFF, 1, t + 2);
        repeat (3) @(negedge clk);
        div_start = 1'b0;
        @(negedge clk);
        chk("b2b_idle_done", {31'b0, div_done}, 32'd0);
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
